mem_block_ctrl: RTL and testbench
=================================

# mem_block_ctrl

Memory-side controller sitting directly below the set-associative data cache. Serves 4-word block fills on a cache miss, and absorbs the cache's write-through single-word stores in a small write buffer that drains to a single-port word array in the background. Models main-memory latency with parameterised, cycle-exact read and write delays.

## Interface
- ADDR_W, 16: word address width.
- DATA_W, 16: word width.
- MEM_AW, 10: array holds 2^MEM_AW words; upper address bits ignored.
- READ_LAT, 4: cycles from read accept to data valid, minimum 2.
- WRITE_LAT, 2: cycles to retire one buffered word into the array, minimum 1.
- WBUF_DEPTH, 4: write-buffer entries, power of two.

- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- mem_read_req  in  1  block read request.
- mem_write_req  in  1  single-word write request.
- mem_addr  in  ADDR_W  word address; for reads, bits [1:0] are ignored (block-aligned).
- mem_wdata  in  DATA_W  write data.
- mem_busy  out  1  request not accepted this cycle.
- mem_rvalid  out  1  one-cycle pulse: block data valid.
- mem_rdata_1..mem_rdata_4  out  DATA_W each  block words at offsets 0..3; held until the next mem_rvalid.
- wbuf_full, wbuf_empty  out  1 each  write-buffer status.
- num_reads, num_writes  out  16 each  accepted-request counters; wrap at 0xFFFF.

## Operation
- Accept rule: a request is accepted on a rising edge where it is high and mem_busy is low. mem_busy = (read FSM != IDLE) | wbuf_full.
- Simultaneous read and write accepted in the same edge: the write is enqueued first and is older than the read.
- Write path: an accepted write is pushed as {addr, data}. The drainer pops the oldest entry and writes the array after WRITE_LAT cycles. It starts or continues only while the read FSM is in IDLE or RD_WAIT. The array is single-port, so a drain in progress freezes its counter during RD_LAT and RD_DONE.
- Read FSM:
  - IDLE→RD_WAIT on accept if the buffer is non-empty (forwarding compiled out).
  - Otherwise IDLE→RD_LAT.
  - RD_WAIT→RD_LAT when the buffer becomes empty.
  - RD_LAT runs READ_LAT-1 cycles, then goes to RD_DONE.
  - RD_DONE lasts 1 cycle, with mem_rvalid=1, then returns to IDLE.
- Read data: the array's 4 words at {addr[ADDR_W-1:2], 2'b00..2'b11}, sampled in the last RD_LAT cycle and registered into mem_rdata_* at the RD_DONE entry edge.
- Counters increment on accept.
- Reset: all outputs are 0, wbuf_empty=1, both FSMs are IDLE, and buffered writes are discarded. A word mid-drain is not written. The array is not reset.

## Timing
- Read, no wait: accept at edge E; mem_rvalid is high during the cycle after edge E+READ_LAT-1. The next request can be accepted at the edge ending RD_DONE.
- Write: accepted write is visible in the buffer the next cycle. With an idle read FSM, the array is updated at edge accept+WRITE_LAT. Back-to-back drains have no bubble.
- wbuf_full deasserts the cycle after a pop.
- Full + pop same edge as a new write: the write is not accepted (busy was high); it is accepted on the next edge.

## Configuration
- WBUF_FORWARD_EN defined:
  - Reads never enter RD_WAIT.
  - At sampling, each buffered entry matching the block overrides the array word, youngest entry winning.
  - A word being drained counts as buffered until popped.
- WBUF_FORWARD_EN undefined: reads wait in RD_WAIT for a full drain; no merge logic.

## Structure
- Package mem_ctrl_pkg:
  - read FSM state enum (IDLE, RD_WAIT, RD_LAT, RD_DONE).
  - drain state enum (DR_IDLE, DR_BUSY).
  - BLOCK_WORDS=4 constant.
  - address/data width localparams.
- Sub-module write_buffer:
  - FIFO with push/pop, full/empty, and head entry.
  - Under WBUF_FORWARD_EN, per-entry valid/addr/data vectors plus an age order for merge.

## Test plan
- Reset, write 0x0010←0xBEEF, wait for wbuf_empty, read 0x0010 → mem_rvalid READ_LAT cycles after accept; mem_rdata_1=0xBEEF; num_writes=1, num_reads=1.
- Writes to 0x0020..0x0023 on 4 consecutive edges with drain slower than issue → wbuf_full=1 and mem_busy=1; a 5th write to 0x0024 is held until the first pop and then accepted; all 5 words are read back correctly.
- With WBUF_FORWARD_EN: write 0x0031←0x1234, then read 0x0030 on the next edge → mem_rvalid exactly READ_LAT cycles after read accept; mem_rdata_2=0x1234. Without the macro: same data, with mem_rvalid delayed by the remaining drain time.
- Writes 0x0040←0x1111 then 0x0040←0x2222, then read 0x0040 → mem_rdata_1=0x2222 in both configurations.
- Assert reset_n=0 during RD_LAT with 2 buffered writes → mem_rvalid never pulses; mem_busy=0, wbuf_empty=1, counters=0; on release, a read of those addresses returns the pre-write array values.
- Read 0x0053 after preloading 0x0050..0x0053 with 0xA0..0xA3 → mem_rdata_1..4 = 0xA0, 0xA1, 0xA2, 0xA3.

Source files
------------

// File: rtl/mem_block_ctrl_pkg.sv
// Shared types and constants for the memory block controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_LAT, RD_DONE} rd_state_t;
  typedef enum logic {DR_IDLE, DR_BUSY} dr_state_t;

  localparam int BLOCK_WORDS = 4;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 16;
  localparam int CNT_W       = 16;

endpackage

// File: rtl/mem_block_ctrl_if.sv
// Cache-to-memory bus: block read / single-word write requests, block data and status.
interface mem_block_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              mem_read_req;
  logic              mem_write_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_busy;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata_1;
  logic [DATA_W-1:0] mem_rdata_2;
  logic [DATA_W-1:0] mem_rdata_3;
  logic [DATA_W-1:0] mem_rdata_4;
  logic              wbuf_full;
  logic              wbuf_empty;
  logic [CNT_W-1:0]  num_reads;
  logic [CNT_W-1:0]  num_writes;

  modport master (
    output mem_read_req, mem_write_req, mem_addr, mem_wdata,
    input  mem_busy, mem_rvalid, mem_rdata_1, mem_rdata_2, mem_rdata_3, mem_rdata_4,
    input  wbuf_full, wbuf_empty, num_reads, num_writes
  );

  modport slave (
    input  mem_read_req, mem_write_req, mem_addr, mem_wdata,
    output mem_busy, mem_rvalid, mem_rdata_1, mem_rdata_2, mem_rdata_3, mem_rdata_4,
    output wbuf_full, wbuf_empty, num_reads, num_writes
  );

endinterface

// File: rtl/mem_block_ctrl_write_buffer.sv
// Write-buffer FIFO of {addr, data} entries. With WBUF_FORWARD_EN it also exposes
// every entry ordered oldest-first (index 0 = head) for read merging.
module write_buffer
  import mem_ctrl_pkg::*;
#(
  parameter int AW    = 10,
  parameter int DW    = DEF_DATA_W,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_push,
  input  logic [AW-1:0] i_push_addr,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_pop,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_last,
  output logic [AW-1:0] o_head_addr,
  output logic [DW-1:0] o_head_data
`ifdef WBUF_FORWARD_EN
  ,
  output logic [DEPTH-1:0] o_ent_valid,
  output logic [AW-1:0]    o_ent_addr [DEPTH],
  output logic [DW-1:0]    o_ent_data [DEPTH]
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_addr[r_wr_ptr] <= i_push_addr;
      r_data[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_last      = (r_count == CW'(1));
  assign o_head_addr = r_addr[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];

`ifdef WBUF_FORWARD_EN
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      o_ent_valid[k] = (r_count > CW'(k));
      o_ent_addr[k]  = r_addr[r_rd_ptr + PW'(k)];
      o_ent_data[k]  = r_data[r_rd_ptr + PW'(k)];
    end
  end
`endif

endmodule

// File: rtl/mem_block_ctrl.sv
// Memory-side block controller: fixed-latency 4-word block reads plus a write buffer
// draining into a single-port array. Define WBUF_FORWARD_EN to merge buffered writes into reads.
//   state   | meaning
//   IDLE    | ready for a request
//   RD_WAIT | read held until the write buffer drains
//   RD_LAT  | array latency countdown, drain frozen
//   RD_DONE | block data registered, rvalid pulse
module mem_block_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_AW     = 10,
  parameter int READ_LAT   = 4,
  parameter int WRITE_LAT  = 2,
  parameter int WBUF_DEPTH = 4
) (
  input logic             clk,
  input logic             reset_n,
  mem_block_ctrl_if.slave mem_if
);

  localparam int RCW = $clog2(READ_LAT);
  localparam int WCW = (WRITE_LAT > 1) ? $clog2(WRITE_LAT) : 1;
  localparam logic [RCW-1:0] RD_LOAD = RCW'(READ_LAT - 2);
  localparam logic [WCW-1:0] WR_LOAD = WCW'((WRITE_LAT > 1) ? WRITE_LAT - 2 : 0);

  rd_state_t         r_rd_state;
  dr_state_t         r_dr_state;
  logic [RCW-1:0]    r_rd_cnt;
  logic [WCW-1:0]    r_dr_cnt;
  logic [MEM_AW-3:0] r_rd_blk;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata [BLOCK_WORDS];
  logic [CNT_W-1:0]  r_num_reads;
  logic [CNT_W-1:0]  r_num_writes;
  logic [DATA_W-1:0] r_mem [2**MEM_AW];

  logic              w_busy;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_full;
  logic              w_empty;
  logic              w_last;
  logic              w_pop;
  logic              w_dr_allow;
  logic [MEM_AW-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic [DATA_W-1:0] w_blk [BLOCK_WORDS];
  logic              w_unused_addr;

`ifdef WBUF_FORWARD_EN
  logic [WBUF_DEPTH-1:0] w_ent_valid;
  logic [MEM_AW-1:0]     w_ent_addr [WBUF_DEPTH];
  logic [DATA_W-1:0]     w_ent_data [WBUF_DEPTH];
`endif

  assign w_busy     = (r_rd_state != IDLE) || w_full;
  assign w_rd_acc   = mem_if.mem_read_req && !w_busy;
  assign w_wr_acc   = mem_if.mem_write_req && !w_busy;
  assign w_dr_allow = (r_rd_state == IDLE) || (r_rd_state == RD_WAIT);
  assign w_pop      = w_dr_allow && !w_empty &&
                      (((r_dr_state == DR_IDLE) && (WRITE_LAT == 1)) ||
                       ((r_dr_state == DR_BUSY) && (r_dr_cnt == '0)));
  assign w_unused_addr = ^mem_if.mem_addr[ADDR_W-1:MEM_AW];

  write_buffer #(
    .AW    (MEM_AW),
    .DW    (DATA_W),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_wr_acc),
    .i_push_addr (mem_if.mem_addr[MEM_AW-1:0]),
    .i_push_data (mem_if.mem_wdata),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_last      (w_last),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data)
`ifdef WBUF_FORWARD_EN
    ,
    .o_ent_valid (w_ent_valid),
    .o_ent_addr  (w_ent_addr),
    .o_ent_data  (w_ent_data)
`endif
  );

  // Array has no reset; its only write port is the drain pop.
  always_ff @(posedge clk) begin
    if (w_pop) r_mem[w_head_addr] <= w_head_data;
  end

  always_comb begin
    for (int i = 0; i < BLOCK_WORDS; i++)
      w_blk[i] = r_mem[{r_rd_blk, 2'(i)}];
`ifdef WBUF_FORWARD_EN
    // Walk oldest to youngest so the youngest matching entry wins.
    for (int k = 0; k < WBUF_DEPTH; k++)
      if (w_ent_valid[k] && (w_ent_addr[k][MEM_AW-1:2] == r_rd_blk))
        w_blk[w_ent_addr[k][1:0]] = w_ent_data[k];
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dr_state <= DR_IDLE;
      r_dr_cnt   <= '0;
    end else if (w_dr_allow) begin
      case (r_dr_state)
        DR_IDLE: if (!w_empty && (WRITE_LAT > 1)) begin
          r_dr_state <= DR_BUSY;
          r_dr_cnt   <= WR_LOAD;
        end
        DR_BUSY: begin
          if (r_dr_cnt == '0) r_dr_state <= DR_IDLE;
          else                r_dr_cnt   <= r_dr_cnt - 1'b1;
        end
        default: r_dr_state <= DR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_state <= IDLE;
      r_rd_cnt   <= '0;
      r_rd_blk   <= '0;
      r_rvalid   <= 1'b0;
      for (int i = 0; i < BLOCK_WORDS; i++) r_rdata[i] <= '0;
    end else begin
      case (r_rd_state)
        IDLE: if (w_rd_acc) begin
          r_rd_blk <= mem_if.mem_addr[MEM_AW-1:2];
          r_rd_cnt <= RD_LOAD;
`ifdef WBUF_FORWARD_EN
          r_rd_state <= RD_LAT;
`else
          r_rd_state <= (!w_empty || w_wr_acc) ? RD_WAIT : RD_LAT;
`endif
        end
        RD_WAIT: if (w_empty || (w_pop && w_last)) r_rd_state <= RD_LAT;
        RD_LAT: begin
          if (r_rd_cnt == '0) begin
            r_rd_state <= RD_DONE;
            r_rvalid   <= 1'b1;
            for (int i = 0; i < BLOCK_WORDS; i++) r_rdata[i] <= w_blk[i];
          end else begin
            r_rd_cnt <= r_rd_cnt - 1'b1;
          end
        end
        RD_DONE: begin
          r_rvalid   <= 1'b0;
          r_rd_state <= IDLE;
        end
        default: r_rd_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_num_reads  <= '0;
      r_num_writes <= '0;
    end else begin
      if (w_rd_acc) r_num_reads  <= r_num_reads + 1'b1;
      if (w_wr_acc) r_num_writes <= r_num_writes + 1'b1;
    end
  end

  assign mem_if.mem_busy    = w_busy;
  assign mem_if.mem_rvalid  = r_rvalid;
  assign mem_if.mem_rdata_1 = r_rdata[0];
  assign mem_if.mem_rdata_2 = r_rdata[1];
  assign mem_if.mem_rdata_3 = r_rdata[2];
  assign mem_if.mem_rdata_4 = r_rdata[3];
  assign mem_if.wbuf_full   = w_full;
  assign mem_if.wbuf_empty  = w_empty;
  assign mem_if.num_reads   = r_num_reads;
  assign mem_if.num_writes  = r_num_writes;

endmodule

// File: tb/tb_mem_block_ctrl.sv
// Directed bench for mem_block_ctrl; expected latencies follow WBUF_FORWARD_EN.
module tb_mem_block_ctrl;

  localparam int RL = 4;
  localparam int WL = 4;
`ifdef WBUF_FORWARD_EN
  localparam int FWD_LAT = RL - 1;
`else
  localparam int FWD_LAT = (RL - 1) + (WL - 1);
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   exp_wr = 0;

  always #5 clk = ~clk;

  mem_block_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_block_ctrl #(
    .ADDR_W(16), .DATA_W(16), .MEM_AW(10),
    .READ_LAT(RL), .WRITE_LAT(WL), .WBUF_DEPTH(4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mem_if  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_quiet();
    for (int n = 0; n < 200 && !(bus.wbuf_empty && !bus.mem_busy); n++) tick();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    for (int n = 0; n < 100 && bus.mem_busy; n++) tick();
    bus.mem_write_req = 1'b1;
    bus.mem_addr = a;
    bus.mem_wdata = d;
    tick();
    bus.mem_write_req = 1'b0;
    exp_wr++;
  endtask

  task automatic wait_rvalid(output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (bus.mem_rvalid === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic do_read(input logic [15:0] a, output int lat);
    for (int n = 0; n < 100 && bus.mem_busy; n++) tick();
    bus.mem_read_req = 1'b1;
    bus.mem_addr = a;
    tick();
    bus.mem_read_req = 1'b0;
    wait_rvalid(lat);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    #2;
    total++; if (bus.mem_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.mem_busy); end
    total++; if (bus.mem_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got %b want 0", bus.mem_rvalid); end
    total++; if (bus.wbuf_full !== 1'b0) begin bad++; $display("FAIL rst_full: got %b want 0", bus.wbuf_full); end
    total++; if (bus.wbuf_empty !== 1'b1) begin bad++; $display("FAIL rst_empty: got %b want 1", bus.wbuf_empty); end
    total++; if (bus.num_reads !== 16'd0) begin bad++; $display("FAIL rst_nreads: got %0d want 0", bus.num_reads); end
    total++; if (bus.num_writes !== 16'd0) begin bad++; $display("FAIL rst_nwrites: got %0d want 0", bus.num_writes); end
    total++;
    if ({bus.mem_rdata_1, bus.mem_rdata_2, bus.mem_rdata_3, bus.mem_rdata_4} !== 64'd0) begin
      bad++;
      $display("FAIL rst_rdata: got %h %h %h %h want all 0", bus.mem_rdata_1, bus.mem_rdata_2,
               bus.mem_rdata_3, bus.mem_rdata_4);
    end
  endtask

  task automatic test_basic();
    int lat;
    do_write(16'h0010, 16'hBEEF);
    wait_quiet();
    total++; if (bus.wbuf_empty !== 1'b1) begin bad++; $display("FAIL basic_drain: empty=%b want 1", bus.wbuf_empty); end
    do_read(16'h0010, lat);
    total++; if (lat != RL - 1) begin bad++; $display("FAIL basic_lat: got %0d want %0d", lat, RL - 1); end
    total++; if (bus.mem_rdata_1 !== 16'hBEEF) begin bad++; $display("FAIL basic_data: got %h want beef", bus.mem_rdata_1); end
    total++; if (bus.num_writes !== 16'd1) begin bad++; $display("FAIL basic_nwrites: got %0d want 1", bus.num_writes); end
    total++; if (bus.num_reads !== 16'd1) begin bad++; $display("FAIL basic_nreads: got %0d want 1", bus.num_reads); end
    tick();
    total++; if (bus.mem_rvalid !== 1'b0) begin bad++; $display("FAIL basic_pulse: rvalid=%b want 0", bus.mem_rvalid); end
    total++; if (bus.mem_rdata_1 !== 16'hBEEF) begin bad++; $display("FAIL basic_hold: got %h want beef", bus.mem_rdata_1); end
  endtask

  task automatic test_full();
    int lat;
    logic [15:0] exp_blk [4];
    wait_quiet();
    for (int i = 0; i < 4; i++) begin
      bus.mem_write_req = 1'b1;
      bus.mem_addr = 16'h0020 + 16'(i);
      bus.mem_wdata = 16'hD000 + 16'(i);
      exp_blk[i] = 16'hD000 + 16'(i);
      tick();
    end
    exp_wr += 4;
    total++; if (bus.wbuf_full !== 1'b1) begin bad++; $display("FAIL full_flag: got %b want 1", bus.wbuf_full); end
    total++; if (bus.mem_busy !== 1'b1) begin bad++; $display("FAIL full_busy: got %b want 1", bus.mem_busy); end
    bus.mem_addr = 16'h0024;
    bus.mem_wdata = 16'hD004;
    tick();
    total++; if (bus.num_writes !== 16'(exp_wr)) begin bad++; $display("FAIL full_held: nwrites=%0d want %0d", bus.num_writes, exp_wr); end
    total++; if (bus.wbuf_full !== 1'b0) begin bad++; $display("FAIL full_pop: full=%b want 0", bus.wbuf_full); end
    tick();
    bus.mem_write_req = 1'b0;
    exp_wr++;
    total++; if (bus.num_writes !== 16'(exp_wr)) begin bad++; $display("FAIL full_accept: nwrites=%0d want %0d", bus.num_writes, exp_wr); end
    wait_quiet();
    do_read(16'h0020, lat);
    total++;
    if ({bus.mem_rdata_1, bus.mem_rdata_2, bus.mem_rdata_3, bus.mem_rdata_4} !==
        {exp_blk[0], exp_blk[1], exp_blk[2], exp_blk[3]}) begin
      bad++;
      $display("FAIL full_readback: got %h %h %h %h want d000 d001 d002 d003", bus.mem_rdata_1,
               bus.mem_rdata_2, bus.mem_rdata_3, bus.mem_rdata_4);
    end
    do_read(16'h0024, lat);
    total++; if (bus.mem_rdata_1 !== 16'hD004) begin bad++; $display("FAIL full_fifth: got %h want d004", bus.mem_rdata_1); end
  endtask

  task automatic test_forward_timing();
    int lat;
    wait_quiet();
    bus.mem_write_req = 1'b1;
    bus.mem_addr = 16'h0031;
    bus.mem_wdata = 16'h1234;
    tick();
    bus.mem_write_req = 1'b0;
    exp_wr++;
    bus.mem_read_req = 1'b1;
    bus.mem_addr = 16'h0030;
    tick();
    bus.mem_read_req = 1'b0;
    wait_rvalid(lat);
    total++; if (lat != FWD_LAT) begin bad++; $display("FAIL fwd_lat: got %0d want %0d", lat, FWD_LAT); end
    total++; if (bus.mem_rdata_2 !== 16'h1234) begin bad++; $display("FAIL fwd_data: got %h want 1234", bus.mem_rdata_2); end
  endtask

  task automatic test_overwrite();
    int lat;
    wait_quiet();
    do_write(16'h0040, 16'h1111);
    do_write(16'h0040, 16'h2222);
    do_read(16'h0040, lat);
    total++; if (lat <= 0) begin bad++; $display("FAIL ovw_timeout: lat=%0d want >0", lat); end
    total++; if (bus.mem_rdata_1 !== 16'h2222) begin bad++; $display("FAIL ovw_data: got %h want 2222", bus.mem_rdata_1); end
  endtask

  task automatic test_block_read();
    int lat;
    wait_quiet();
    for (int i = 0; i < 4; i++) do_write(16'h0050 + 16'(i), 16'h00A0 + 16'(i));
    wait_quiet();
    do_read(16'h0053, lat);
    total++; if (lat != RL - 1) begin bad++; $display("FAIL blk_lat: got %0d want %0d", lat, RL - 1); end
    total++; if (bus.mem_rdata_1 !== 16'h00A0) begin bad++; $display("FAIL blk_w0: got %h want 00a0", bus.mem_rdata_1); end
    total++; if (bus.mem_rdata_2 !== 16'h00A1) begin bad++; $display("FAIL blk_w1: got %h want 00a1", bus.mem_rdata_2); end
    total++; if (bus.mem_rdata_3 !== 16'h00A2) begin bad++; $display("FAIL blk_w2: got %h want 00a2", bus.mem_rdata_3); end
    total++; if (bus.mem_rdata_4 !== 16'h00A3) begin bad++; $display("FAIL blk_w3: got %h want 00a3", bus.mem_rdata_4); end
  endtask

  task automatic test_reset_midread();
    int lat;
    bit seen;
    wait_quiet();
    do_write(16'h0060, 16'h0A0A);
    do_write(16'h0061, 16'h0B0B);
    wait_quiet();
    do_write(16'h0060, 16'hDEAD);
    do_write(16'h0061, 16'hBEEF);
    bus.mem_read_req = 1'b1;
    bus.mem_addr = 16'h0060;
    tick();
    bus.mem_read_req = 1'b0;
    tick();
    reset_n = 1'b0;
    #2;
    total++; if (bus.mem_busy !== 1'b0) begin bad++; $display("FAIL mrst_busy: got %b want 0", bus.mem_busy); end
    total++; if (bus.wbuf_empty !== 1'b1) begin bad++; $display("FAIL mrst_empty: got %b want 1", bus.wbuf_empty); end
    total++;
    if ({bus.num_reads, bus.num_writes} !== 32'd0) begin
      bad++;
      $display("FAIL mrst_counters: got %0d/%0d want 0/0", bus.num_reads, bus.num_writes);
    end
    seen = bus.mem_rvalid;
    for (int n = 0; n < 3; n++) begin tick(); if (bus.mem_rvalid !== 1'b0) seen = 1'b1; end
    reset_n = 1'b1;
    for (int n = 0; n < 8; n++) begin tick(); if (bus.mem_rvalid !== 1'b0) seen = 1'b1; end
    total++; if (seen) begin bad++; $display("FAIL mrst_rvalid: pulse seen=1 want 0"); end
    do_read(16'h0060, lat);
    total++; if (bus.mem_rdata_1 !== 16'h0A0A) begin bad++; $display("FAIL mrst_w0: got %h want 0a0a", bus.mem_rdata_1); end
    total++; if (bus.mem_rdata_2 !== 16'h0B0B) begin bad++; $display("FAIL mrst_w1: got %h want 0b0b", bus.mem_rdata_2); end
    total++;
    if ({bus.num_reads, bus.num_writes} !== {16'd1, 16'd0}) begin
      bad++;
      $display("FAIL mrst_recount: got %0d/%0d want 1/0", bus.num_reads, bus.num_writes);
    end
  endtask

  initial begin
    bus.mem_read_req = 1'b0;
    bus.mem_write_req = 1'b0;
    bus.mem_addr = '0;
    bus.mem_wdata = '0;
    test_reset();
    test_basic();
    test_full();
    test_forward_timing();
    test_overwrite();
    test_block_read();
    test_reset_midread();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached before test done");
    $fatal(1);
  end

endmodule
